alu4_rr_scheduler: RTL and testbench
====================================

Name: alu4_rr_scheduler

Overview:
- Shares one combinational 4-bit add/sub/mul ALU (a, b, 2-bit operation in; 8-bit Result out) between NREQ requesters.
- Performs round-robin arbitration with valid/ready handshakes.
- Registers the ALU operands, captures the 8-bit result and returns it on a single response channel tagged with the requester id.
- Sits between the requester fabric and the ALU instance; the ALU itself is external.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of the requester id; must satisfy 2^IDW >= NREQ

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  4*NREQ  operand a; requester i occupies bits [4i+3:4i]
- req_b  in  4*NREQ  operand b, same packing as req_a
- req_op  in  2*NREQ  operation per requester: 00 add, 01 sub, 11 mul, 10 reserved
- alu_a  out  4  registered operand a to ALU
- alu_b  out  4  registered operand b to ALU
- alu_op  out  2  registered operation to ALU
- alu_result  in  8  ALU Result[7:0]
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_data  out  8  captured result
- resp_id  out  IDW  index of the requester that issued the request
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: req_ready=0, alu_a=0, alu_b=0, alu_op=00, resp_valid=0, resp_data=0, resp_id=0, busy=0, rr pointer=0, state=IDLE.
- FSM states and transitions:
  - IDLE: req_ready is combinational. Asserted only for the winner: the first i with req_valid[i]=1, searching from the rr pointer upward with wrap. If no req_valid is high, remain in IDLE.
  - IDLE grant: on the handshake cycle, latch req_a, req_b and req_op of the winner into alu_a, alu_b and alu_op. Latch the winner index into resp_id. Set the rr pointer to (winner+1) mod NREQ. Go to EXEC.
  - EXEC: exactly one cycle. The ALU settles on the registered inputs. At the end of the cycle, resp_data<=alu_result and resp_valid<=1. Go to RESP.
  - RESP: hold resp_valid, resp_data and resp_id stable until resp_ready=1. On the handshake, resp_valid<=0 and go to IDLE. req_ready=0 throughout.
- Latency:
  - grant to resp_valid = 2 cycles.
  - Minimum issue interval = 3 cycles when resp_ready is held high. No back-to-back overlap; only one operation is in flight at any time.
- alu_a, alu_b and alu_op hold their last values after the operation completes; they are not cleared.
- Reserved op 10 is forwarded unchanged to the ALU. The result is whatever the ALU returns; the ALU contract defines it as 8'h00. The scheduler performs no checking.
- Widths and arithmetic:
  - The rr pointer is IDW bits and wraps from NREQ-1 to 0.
  - Pointer values >= NREQ never occur.
- Fairness: a requester that keeps req_valid asserted is granted within NREQ grants.
- Boundary conditions:
  - A requester dropping req_valid before it is granted is legal; it is simply not granted.
  - Changing req_a, req_b or req_op while not granted has no effect.
  - resp_ready asserted in IDLE or EXEC is ignored.
  - All NREQ requesters valid simultaneously: grants proceed in order ptr, ptr+1, ... with wrap.
  - rst asserted in any state: next cycle is IDLE with all reset values. An in-flight response is discarded. The rr pointer returns to 0.

Test Plan:
- Reset, then requester 0 sends a=3, b=5, op=00 (add): req_ready[0]=1 on the same cycle; resp_valid rises 2 cycles later with resp_data=8'h08 and resp_id=0.
- Requester 2 sends a=15, b=15, op=11 (mul) with resp_ready held low for 4 cycles: resp_data=8'hE1 and resp_id=2 stay stable for all 4 cycles; no req_ready is asserted; the handshake happens on the first cycle resp_ready=1.
- All 4 requesters valid continuously with resp_ready=1: grant order is 0,1,2,3,0; grants occur every 3 cycles; resp_id follows the same order.
- rr pointer=3 after a grant to requester 2; requesters 0 and 3 are then valid: requester 3 is granted first, then 0.
- rst pulsed during the RESP state: resp_valid=0 and busy=0 on the next cycle; the next grant starts searching from requester 0.
- Requester 1 sends op=10 (reserved), a=9, b=4: alu_op=10 is presented to the ALU and resp_data=8'h00 is returned with resp_id=1.

Source files
------------

// File: rtl/alu4_rr_scheduler_if.sv
// Requester-side and response-side handshake bundle for the shared-ALU scheduler.
// master = requester fabric, slave = scheduler.
interface alu4_rr_scheduler_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_a;
   logic [4*NREQ-1:0] req_b;
   logic [2*NREQ-1:0] req_op;
   logic              resp_valid;
   logic              resp_ready;
   logic [7:0]        resp_data;
   logic [IDW-1:0]    resp_id;

   modport master (
      output req_valid, req_a, req_b, req_op, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id
   );
endinterface

// File: rtl/alu4_rr_scheduler.sv
// Round-robin scheduler sharing one external 4-bit ALU among NREQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until accepted).
module alu4_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   alu4_rr_scheduler_if.slave  bus,
   output logic [3:0]          alu_a_o,
   output logic [3:0]          alu_b_o,
   output logic [1:0]          alu_op_o,
   input  logic [7:0]          alu_result_i,
   output logic                busy_o
);
   localparam int SW = IDW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [3:0]     a_q, a_d;
   logic [3:0]     b_q, b_d;
   logic [1:0]     op_q, op_d;
   logic [7:0]     data_q, data_d;
   logic           vld_q, vld_d;
   logic [NREQ-1:0] ready;
   logic           found;
   logic [IDW-1:0] win;
   logic [SW-1:0]  idx;

   // First valid requester at or after the pointer, wrapping at NREQ.
   always_comb begin : search
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr_q} + SW'(k);
         if (idx >= SW'(NREQ)) idx = idx - SW'(NREQ);
         if (!found && bus.req_valid[idx[IDW-1:0]]) begin
            found = 1'b1;
            win   = idx[IDW-1:0];
         end
      end
   end

   always_comb begin : fsm
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      data_d  = data_q;
      vld_d   = vld_q;
      ready   = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               ready[win] = 1'b1;
               a_d        = bus.req_a[{win, 2'b00} +: 4];
               b_d        = bus.req_b[{win, 2'b00} +: 4];
               op_d       = bus.req_op[{win, 1'b0} +: 2];
               id_d       = win;
               ptr_d      = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
               state_d    = EXEC;
            end
         end
         EXEC: begin
            data_d  = alu_result_i;
            vld_d   = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
      end
   end

   assign bus.req_ready  = ready;
   assign bus.resp_valid = vld_q;
   assign bus.resp_data  = data_q;
   assign bus.resp_id    = id_q;
   assign alu_a_o        = a_q;
   assign alu_b_o        = b_q;
   assign alu_op_o       = op_q;
   assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_alu4_rr_scheduler.sv
// Bench for alu4_rr_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_alu4_rr_scheduler;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu4_rr_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   logic [3:0] alu_a, alu_b;
   logic [1:0] alu_op;
   logic [7:0] alu_result;
   logic       busy;

   logic [NREQ-1:0] tv;
   logic [3:0]      ta   [NREQ];
   logic [3:0]      tb_b [NREQ];
   logic [1:0]      top  [NREQ];

   assign bus.req_valid = tv;
   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign bus.req_a[4*g +: 4]  = ta[g];
      assign bus.req_b[4*g +: 4]  = tb_b[g];
      assign bus.req_op[2*g +: 2] = top[g];
   end

   alu4_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .alu_a_o      (alu_a),
      .alu_b_o      (alu_b),
      .alu_op_o     (alu_op),
      .alu_result_i (alu_result),
      .busy_o       (busy)
   );

   function automatic logic [7:0] alu_fn(logic [3:0] a, logic [3:0] b, logic [1:0] op);
      case (op)
         2'b00:   return {4'b0, a} + {4'b0, b};
         2'b01:   return {4'b0, a} - {4'b0, b};
         2'b11:   return {4'b0, a} * {4'b0, b};
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_op);

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: pointer, one outstanding transaction, cycles since grant.
   int         m_ptr, m_cnt, m_id, last_grant;
   bit         m_busy;
   logic [7:0] m_data;
   logic [3:0] m_a, m_b;
   logic [1:0] m_op;

   function automatic int pick(logic [NREQ-1:0] v, int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_busy = 0; m_cnt = 0; m_id = 0; m_data = 0;
      m_a = 0; m_b = 0; m_op = 0;
   endtask

   task automatic step();
      int w;
      logic [NREQ-1:0] exp_rdy;
      bit resp_exp;
      #1;
      w        = m_busy ? -1 : pick(tv, m_ptr);
      exp_rdy  = (w >= 0) ? (NREQ'(1) << w) : '0;
      resp_exp = m_busy && (m_cnt >= 2);
      check_eq("req_ready", bus.req_ready, exp_rdy);
      check_eq("busy", busy, m_busy);
      check_eq("resp_valid", bus.resp_valid, resp_exp);
      if (resp_exp) begin
         check_eq("resp_data", bus.resp_data, m_data);
         check_eq("resp_id", bus.resp_id, m_id);
      end
      check_eq("alu_a", alu_a, m_a);
      check_eq("alu_b", alu_b, m_b);
      check_eq("alu_op", alu_op, m_op);
      last_grant = -1;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (!m_busy) begin
         if (w >= 0) begin
            m_busy = 1; m_cnt = 1; m_id = w;
            m_a = ta[w]; m_b = tb_b[w]; m_op = top[w];
            m_data = alu_fn(m_a, m_b, m_op);
            m_ptr = (w + 1) % NREQ;
            last_grant = w;
         end
      end else if (m_cnt >= 2) begin
         if (bus.resp_ready) m_busy = 0;
      end else begin
         m_cnt = 2;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tv = '0;
      bus.resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   int gq[$];
   int gc[$];

   initial begin
      for (int i = 0; i < NREQ; i++) begin ta[i] = 0; tb_b[i] = 0; top[i] = 0; end
      do_reset();

      // Reset values
      #1;
      check_eq("rst_resp_valid", bus.resp_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_req_ready", bus.req_ready, 0);
      check_eq("rst_resp_data", bus.resp_data, 0);
      check_eq("rst_resp_id", bus.resp_id, 0);
      check_eq("rst_alu", {alu_a, alu_b, alu_op}, 0);

      // Requester 0: 3 + 5
      tv = 4'b0001; ta[0] = 3; tb_b[0] = 5; top[0] = 2'b00; bus.resp_ready = 1'b1;
      #1 check_eq("t1_ready", bus.req_ready, 4'b0001);
      step();
      tv = '0;
      step();
      #1;
      check_eq("t1_valid", bus.resp_valid, 1);
      check_eq("t1_data", bus.resp_data, 8'h08);
      check_eq("t1_id", bus.resp_id, 0);
      step();

      // Requester 2: 15 * 15 with response stalled for 4 cycles
      tv = 4'b0100; ta[2] = 15; tb_b[2] = 15; top[2] = 2'b11; bus.resp_ready = 1'b0;
      step();
      check_eq("t2_grant", last_grant, 2);
      tv = 4'b1001; ta[0] = 7; tb_b[0] = 2; top[0] = 2'b01; ta[3] = 4; tb_b[3] = 6; top[3] = 2'b00;
      step();
      for (int c = 0; c < 4; c++) begin
         #1;
         check_eq("t2_hold_data", bus.resp_data, 8'hE1);
         check_eq("t2_hold_id", bus.resp_id, 2);
         check_eq("t2_hold_ready", bus.req_ready, 0);
         step();
      end
      bus.resp_ready = 1'b1;
      step();
      #1 check_eq("t2_done", bus.resp_valid, 0);

      // Pointer at 3, requesters 0 and 3 pending
      step();
      check_eq("t4_first", last_grant, 3);
      step(); step();
      step();
      check_eq("t4_second", last_grant, 0);
      tv = '0;
      step(); step();

      // All requesters continuously valid
      do_reset();
      tv = 4'b1111; bus.resp_ready = 1'b1;
      for (int c = 0; c < 13; c++) begin
         step();
         if (last_grant >= 0) begin gq.push_back(last_grant); gc.push_back(c); end
      end
      check_eq("t3_ngrants", gq.size(), 5);
      for (int i = 0; i < gq.size() && i < 5; i++) begin
         check_eq("t3_order", gq[i], i % NREQ);
         if (i > 0) check_eq("t3_interval", gc[i] - gc[i-1], 3);
      end
      tv = '0;
      step(); step(); step();

      // Reset while response pending
      do_reset();
      tv = 4'b0100; ta[2] = 5; tb_b[2] = 6; top[2] = 2'b00; bus.resp_ready = 1'b0;
      step();
      tv = '0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check_eq("t5_valid", bus.resp_valid, 0);
      check_eq("t5_busy", busy, 0);
      tv = 4'b1010; ta[1] = 2; tb_b[1] = 2; top[1] = 2'b00;
      step();
      check_eq("t5_grant", last_grant, 1);
      tv = '0; bus.resp_ready = 1'b1;
      step(); step();

      // Reserved op from requester 1
      tv = 4'b0010; ta[1] = 9; tb_b[1] = 4; top[1] = 2'b10;
      step();
      check_eq("t6_grant", last_grant, 1);
      tv = '0;
      #1 check_eq("t6_alu_op", alu_op, 2'b10);
      step();
      #1;
      check_eq("t6_data", bus.resp_data, 8'h00);
      check_eq("t6_id", bus.resp_id, 1);
      step();

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         tv = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            ta[i] = 4'($urandom); tb_b[i] = 4'($urandom); top[i] = 2'($urandom);
         end
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 60) == 0);
         step();
      end
      rst = 1'b0; tv = '0; bus.resp_ready = 1'b1;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
